// File: rtl/change_dispense_ctrl.sv
// Change dispenser controller: greedy quarter/dime/nickel payout from three coin tubes,
// one ejector pulse at a time with a fixed settling gap, plus deposit-driven tube refill.
module change_dispense_ctrl #(
  parameter int unsigned GAP      = 2,
  parameter int unsigned TUBE_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] amount,
  input  logic       ej_ready,
  input  logic       depQ,
  input  logic       depD,
  input  logic       depN,
  output logic       busy,
  output logic       dispQuarter,
  output logic       dispDime,
  output logic       dispNickel,
  output logic       done,
  output logic       short,
  output logic [5:0] remaining,
  output logic [3:0] cntQ,
  output logic [3:0] cntD,
  output logic [3:0] cntN
);

  localparam int unsigned AW = 6;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] TMAX      = CW'(TUBE_MAX);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(GAP - 1);

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_EJECT, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {C_NONE, C_Q, C_D, C_N} coin_t;

  state_t         state;
  coin_t          coin;
  coin_t          pick;
  logic [AW-1:0]  coin_val;
  logic [CW-1:0]  wait_cnt;
  logic           ej_q, ej_d, ej_n;

  // Largest coin that fits the balance and is still in stock.
  always_comb begin
    pick = C_NONE;
    if (cntQ != '0 && remaining >= AW'(5))      pick = C_Q;
    else if (cntD != '0 && remaining >= AW'(2)) pick = C_D;
    else if (cntN != '0 && remaining >= AW'(1)) pick = C_N;
  end

  always_comb begin
    coin_val = '0;
    case (coin)
      C_Q:     coin_val = AW'(5);
      C_D:     coin_val = AW'(2);
      C_N:     coin_val = AW'(1);
      default: coin_val = '0;
    endcase
  end

  assign ej_q = (state == S_EJECT) && (coin == C_Q);
  assign ej_d = (state == S_EJECT) && (coin == C_D);
  assign ej_n = (state == S_EJECT) && (coin == C_N);

  // Deposit saturates at capacity; a deposit and an ejection on one tube cancel out.
  function automatic logic [CW-1:0] tube_next(input logic [CW-1:0] cnt,
                                              input logic dep, input logic ej);
    logic [CW-1:0] r;
    r = cnt;
    if (dep && !ej)      r = (cnt >= TMAX) ? cnt : cnt + CW'(1);
    else if (ej && !dep) r = cnt - CW'(1);
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      coin        <= C_NONE;
      wait_cnt    <= '0;
      remaining   <= '0;
      cntQ        <= TMAX;
      cntD        <= TMAX;
      cntN        <= TMAX;
      busy        <= 1'b0;
      done        <= 1'b0;
      short       <= 1'b0;
      dispQuarter <= 1'b0;
      dispDime    <= 1'b0;
      dispNickel  <= 1'b0;
    end else begin
      cntQ        <= tube_next(cntQ, depQ, ej_q);
      cntD        <= tube_next(cntD, depD, ej_d);
      cntN        <= tube_next(cntN, depN, ej_n);
      done        <= 1'b0;
      dispQuarter <= 1'b0;
      dispDime    <= 1'b0;
      dispNickel  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            remaining <= amount;
            busy      <= 1'b1;
            if (amount == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
              short <= 1'b0;
            end else begin
              state <= S_SELECT;
            end
          end
        end
        S_SELECT: begin
          if (pick == C_NONE) begin
            state <= S_DONE;
            done  <= 1'b1;
            short <= (remaining != '0);
          end else if (ej_ready) begin
            state       <= S_EJECT;
            coin        <= pick;
            dispQuarter <= (pick == C_Q);
            dispDime    <= (pick == C_D);
            dispNickel  <= (pick == C_N);
          end
        end
        S_EJECT: begin
          remaining <= remaining - coin_val;
          wait_cnt  <= WAIT_LOAD;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == '0) state <= S_SELECT;
          else                wait_cnt <= wait_cnt - CW'(1);
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          short <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
